// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame buffer: frames become visible to the consumer only once
// they complete cleanly; errored, aborted or overflowed frames are rolled back and counted.
module rx_frame_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned READY_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           good_frame_cnt,
  output logic [15:0]           drop_frame_cnt,
  output logic                  frame_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic {StWrite, StDrop} wr_state_e;

  logic [DATA_WIDTH:0] mem [DEPTH];

  wr_state_e           wr_state;
  logic [PW-1:0]       wr_ptr_cur;
  logic [PW-1:0]       wr_ptr_commit;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       fetch_ptr;
  logic [PW-1:0]       used;
  logic [PW-1:0]       free;
  logic                full;
  logic                mem_we;
  logic                fetch_valid;
  logic [DATA_WIDTH:0] fetch_data;
  logic                fetch_avail;
  logic                out_free;

  // Occupancy counts the speculative frame so it can never overwrite unread committed data.
  assign used   = wr_ptr_cur - rd_ptr;
  assign free   = DEPTH_P - used;
  assign full   = (used == DEPTH_P);
  assign mem_we = s_axis_tvalid && (wr_state == StWrite) && !s_axis_tuser && !full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state       <= StWrite;
      wr_ptr_cur     <= '0;
      wr_ptr_commit  <= '0;
      good_frame_cnt <= '0;
      drop_frame_cnt <= '0;
      frame_drop     <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      if (s_axis_tvalid) begin
        unique case (wr_state)
          StWrite: begin
            if (s_axis_tuser) begin
              wr_ptr_cur     <= wr_ptr_commit;
              drop_frame_cnt <= drop_frame_cnt + 16'd1;
              frame_drop     <= 1'b1;
            end else if (full) begin
              if (s_axis_tlast) begin
                wr_ptr_cur     <= wr_ptr_commit;
                drop_frame_cnt <= drop_frame_cnt + 16'd1;
                frame_drop     <= 1'b1;
              end else begin
                wr_state <= StDrop;
              end
            end else begin
              wr_ptr_cur <= wr_ptr_cur + ONE_P;
              if (s_axis_tlast) begin
                wr_ptr_commit  <= wr_ptr_cur + ONE_P;
                good_frame_cnt <= good_frame_cnt + 16'd1;
              end
            end
          end
          StDrop: begin
            if (s_axis_tlast || s_axis_tuser) begin
              wr_ptr_cur     <= wr_ptr_commit;
              drop_frame_cnt <= drop_frame_cnt + 16'd1;
              frame_drop     <= 1'b1;
              wr_state       <= StWrite;
            end
          end
          default: wr_state <= StWrite;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Two-stage read: fetch register then output register. fetch_ptr runs ahead of rd_ptr,
  // which only moves on accepted beats so occupancy covers entries still in flight.
  assign fetch_avail = (fetch_ptr != wr_ptr_commit);
  assign out_free    = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      fetch_valid   <= 1'b0;
      fetch_data    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (out_free) begin
        m_axis_tvalid <= fetch_valid;
        if (fetch_valid) begin
          {m_axis_tlast, m_axis_tdata} <= fetch_data;
        end
      end
      if (!fetch_valid || out_free) begin
        fetch_valid <= fetch_avail;
        if (fetch_avail) begin
          fetch_data <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
          fetch_ptr  <= fetch_ptr + ONE_P;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_axis_trdy <= 1'b1;
    end else begin
      s_axis_trdy <= (32'(free) >= READY_THRESH);
    end
  end

endmodule
